// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the 16-bit datapath: captures one instruction per
// start strobe and walks the datapath through read, ALU and write-back cycles.
module datapath_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        w,
  output logic        done,
  output logic        err,
  output logic [15:0] datapath_in,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic       is_mov_imm, is_mov_reg, is_arith, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_arith   = (opcode == 3'b101);
  assign is_cmp     = is_arith && (op == 2'b01);

  // Immediate comes straight from the held instruction, so it is stable until the next capture.
  assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    w        = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (start) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm) begin
          state_d = S_WRITE_IMM;
        end else if (is_mov_reg || (is_arith && op == 2'b11)) begin
          state_d = S_GET_B;
        end else if (is_arith) begin
          state_d = S_GET_A;
        end else begin
          err     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        // MOV reg is 0 + shifted B, so the A operand is forced to zero.
        shift = sh;
        asel  = is_mov_reg;
        ALUop = is_mov_reg ? 2'b00 : op;
        if (is_cmp) begin
          loads   = 1'b1;
          done    = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
        done     = 1'b1;
        state_d  = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
        done     = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule
